bus_arb: RTL and testbench



---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_tmo.sv | 39 +++
 rtl/bus_arb.sv | 126 ++++++++++++
 tb/tb_bus_arb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master system bus arbiter.
package bus_pkg;

    localparam int unsigned ADDR_W      = 22;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned TMO_DEFAULT = 1023;

    localparam logic [DATA_W-1:0] TMO_DATA = 32'h0000_0000;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Master-side request payload routed onto the slave bus
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_req_t;

endpackage

// File: rtl/bus_tmo.sv
// Watchdog: counts unacknowledged BUSY cycles and flags expiry in the last allowed one.
module bus_tmo
    import bus_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = TMO_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TMO_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Idle holds the counter at zero, so it is clear on every BUSY entry
    always_comb begin
        cnt_d = cnt_q;
        if (!busy_i) begin
            cnt_d = '0;
        end else if (!ack_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = busy_i && (cnt_q == LIMIT);

endmodule

// File: rtl/bus_arb.sv
// Round-robin two-master bus arbiter with combinational return path and
// watchdog termination of unacknowledged transactions.
module bus_arb
    import bus_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = TMO_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_dout_i,
    output logic [DATA_W-1:0] m0_din_o,
    output logic              m0_ack_o,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_dout_i,
    output logic [DATA_W-1:0] m1_din_o,
    output logic              m1_ack_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_dout_o,
    input  logic [DATA_W-1:0] bus_din_i,
    input  logic              bus_ack_i,
    output logic              tmo_o,
    output logic [ADDR_W-1:0] tmo_addr_o,
    output logic              tmo_mst_o
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] tmo_addr_q, tmo_addr_d;
    logic              tmo_mst_q, tmo_mst_d;

    bus_req_t          m0_req, m1_req, own_req;
    logic              own_stb;
    logic              busy;
    logic              expire;
    logic              timeout_c;
    logic              own_ack;
    logic [DATA_W-1:0] own_din;

    assign m0_req  = {m0_we_i, m0_addr_i, m0_dout_i};
    assign m1_req  = {m1_we_i, m1_addr_i, m1_dout_i};
    assign own_req = owner_q ? m1_req : m0_req;
    assign own_stb = owner_q ? m1_stb_i : m0_stb_i;
    assign busy    = (state_q == ARB_BUSY);

    bus_tmo #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy_i   (busy),
        .ack_i    (bus_ack_i),
        .expire_o (expire)
    );

    // A real slave ack in the expiry cycle takes precedence over the timeout
    assign timeout_c = busy && own_stb && expire && !bus_ack_i;
    assign own_ack   = busy && own_stb && (bus_ack_i || expire);
    assign own_din   = (busy && !timeout_c) ? bus_din_i : TMO_DATA;

    assign m0_ack_o  = own_ack && !owner_q;
    assign m1_ack_o  = own_ack && owner_q;
    assign m0_din_o  = owner_q ? '0 : own_din;
    assign m1_din_o  = owner_q ? own_din : '0;

    assign bus_stb_o  = busy && own_stb && !timeout_c;
    assign bus_we_o   = own_req.we;
    assign bus_addr_o = own_req.addr;
    assign bus_dout_o = own_req.data;

    assign tmo_o      = timeout_c;
    assign tmo_addr_o = tmo_addr_q;
    assign tmo_mst_o  = tmo_mst_q;

    // Grant selection, transaction termination and timeout capture
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        tmo_addr_d = tmo_addr_q;
        tmo_mst_d  = tmo_mst_q;
        case (state_q)
            ARB_IDLE: begin
                if (m0_stb_i || m1_stb_i) begin
                    owner_d = (m0_stb_i && m1_stb_i) ? ~last_q : m1_stb_i;
                    last_d  = owner_d;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!own_stb || bus_ack_i || expire) begin
                    state_d = ARB_IDLE;
                end
                if (timeout_c) begin
                    tmo_addr_d = own_req.addr;
                    tmo_mst_d  = owner_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b0;
            tmo_addr_q <= '0;
            tmo_mst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            tmo_addr_q <= tmo_addr_d;
            tmo_mst_q  <= tmo_mst_d;
        end
    end

endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: directed scenarios plus random traffic against a transaction-level model.
module tb_bus_arb;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s0, w0, s1, w1;
    logic [21:0] a0, a1;
    logic [31:0] d0, d1;
    logic [31:0] m0_din, m1_din;
    logic        m0_ack, m1_ack;
    logic        bus_stb, bus_we;
    logic [21:0] bus_addr;
    logic [31:0] bus_dout;
    logic [31:0] din_in;
    logic        ack_in;
    logic        tmo;
    logic [21:0] tmo_addr;
    logic        tmo_mst;

    always #5 clk = ~clk;

    bus_arb #(.TMO_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_stb_i   (s0),
        .m0_we_i    (w0),
        .m0_addr_i  (a0),
        .m0_dout_i  (d0),
        .m0_din_o   (m0_din),
        .m0_ack_o   (m0_ack),
        .m1_stb_i   (s1),
        .m1_we_i    (w1),
        .m1_addr_i  (a1),
        .m1_dout_i  (d1),
        .m1_din_o   (m1_din),
        .m1_ack_o   (m1_ack),
        .bus_stb_o  (bus_stb),
        .bus_we_o   (bus_we),
        .bus_addr_o (bus_addr),
        .bus_dout_o (bus_dout),
        .bus_din_i  (din_in),
        .bus_ack_i  (ack_in),
        .tmo_o      (tmo),
        .tmo_addr_o (tmo_addr),
        .tmo_mst_o  (tmo_mst)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: who holds the bus, for how many cycles, and the last timeout record
    bit          m_busy, m_owner, m_last, m_tmo_mst;
    int          m_age;
    logic [21:0] m_tmo_addr;
    bit          exp_ack0, exp_ack1;
    int          lat;
    bit          rand_mode;
    bit          act0, act1;

    logic        o_bus_stb, o_m0_ack, o_m1_ack, o_tmo;
    logic [31:0] o_m0_din, o_m1_din;
    logic [21:0] o_bus_addr;

    int k;
    bit got;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    // Slave answers lat cycles after the first strobed cycle; random mode adds idle noise
    task automatic drive_slave();
        ack_in = m_busy && (m_age - 1 == lat);
        if (rand_mode) begin
            din_in = $urandom;
            if (!m_busy && $urandom_range(0, 7) == 0) ack_in = 1'b1;
        end
    endtask

    // One clock cycle: entered and left at posedge+1, checked mid-cycle
    task automatic step();
        bit          own_stb, expire, tmo_e, e_stb, e_ack;
        logic [31:0] e_din;
        drive_slave();
        #4;
        own_stb  = m_owner ? s1 : s0;
        expire   = m_busy && own_stb && (m_age == TMO);
        tmo_e    = expire && !ack_in;
        e_stb    = m_busy && own_stb && !tmo_e;
        e_ack    = m_busy && own_stb && (ack_in || expire);
        e_din    = (m_busy && !tmo_e) ? din_in : 32'h0;
        exp_ack0 = e_ack && !m_owner;
        exp_ack1 = e_ack && m_owner;
        o_bus_stb = bus_stb; o_m0_ack = m0_ack; o_m1_ack = m1_ack; o_tmo = tmo;
        o_m0_din = m0_din; o_m1_din = m1_din; o_bus_addr = bus_addr;
        check("bus_stb", bus_stb, 32'(e_stb));
        check("tmo", tmo, 32'(tmo_e));
        check("m0_ack", m0_ack, 32'(exp_ack0));
        check("m1_ack", m1_ack, 32'(exp_ack1));
        check("m0_din", m0_din, m_owner ? 32'h0 : e_din);
        check("m1_din", m1_din, m_owner ? e_din : 32'h0);
        check("tmo_addr", 32'(tmo_addr), 32'(m_tmo_addr));
        check("tmo_mst", tmo_mst, 32'(m_tmo_mst));
        if (e_stb) begin
            check("bus_addr", 32'(bus_addr), 32'(m_owner ? a1 : a0));
            check("bus_we", bus_we, 32'(m_owner ? w1 : w0));
            check("bus_dout", bus_dout, m_owner ? d1 : d0);
        end
        @(posedge clk);
        if (!m_busy) begin
            if (s0 || s1) begin
                m_owner = (s0 && s1) ? !m_last : s1;
                m_last  = m_owner;
                m_busy  = 1'b1;
                m_age   = 1;
                if (rand_mode) lat = $urandom_range(0, 11);
            end
        end else if (!own_stb || ack_in || expire) begin
            m_busy = 1'b0;
            if (tmo_e) begin
                m_tmo_addr = m_owner ? a1 : a0;
                m_tmo_mst  = m_owner;
            end
        end else begin
            m_age++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_busy = 0; m_owner = 0; m_last = 0; m_age = 0; m_tmo_addr = '0; m_tmo_mst = 0;
        #1;
        check("rst_bus_stb", bus_stb, 32'h0);
        check("rst_tmo", tmo, 32'h0);
        check("rst_m0_ack", m0_ack, 32'h0);
        check("rst_m1_ack", m1_ack, 32'h0);
        check("rst_m0_din", m0_din, 32'h0);
        check("rst_m1_din", m1_din, 32'h0);
        check("rst_tmo_addr", 32'(tmo_addr), 32'h0);
        check("rst_tmo_mst", tmo_mst, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Random masters: hold a request until acked, occasionally abandon it
    task automatic masters_update();
        if (exp_ack0) act0 = 0;
        if (exp_ack1) act1 = 0;
        if (act0 && $urandom_range(0, 49) == 0) act0 = 0;
        if (act1 && $urandom_range(0, 49) == 0) act1 = 0;
        if (!act0 && $urandom_range(0, 2) == 0) begin
            act0 = 1; w0 = 1'($urandom); d0 = $urandom;
        end
        if (!act1 && $urandom_range(0, 2) == 0) begin
            act1 = 1; w1 = 1'($urandom); d1 = $urandom;
        end
        if (!act0) a0 = 22'($urandom);
        else if (!s0) a0 = 22'($urandom);
        if (!act1) a1 = 22'($urandom);
        else if (!s1) a1 = 22'($urandom);
        s0 = act0;
        s1 = act1;
    endtask

    initial begin
        s0 = 0; s1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        ack_in = 0; din_in = '0; lat = 0; rand_mode = 0; act0 = 0; act1 = 0;
        do_reset();

        // Both masters requesting continuously: m1 first, then strict alternation
        s0 = 1; s1 = 1; a0 = 22'h000100; a1 = 22'h000200; w0 = 0; w1 = 1;
        d0 = 32'h0000_AAAA; d1 = 32'h0000_BBBB; din_in = 32'hA5A5_0001; lat = 0; k = 0;
        for (int i = 0; i < 24 && k < 8; i++) begin
            step();
            if (o_m0_ack || o_m1_ack) begin
                check("alt_order", 32'(o_m1_ack), 32'(k % 2 == 0));
                k++;
            end
        end
        check("alt_count", k, 8);
        s0 = 0; s1 = 0; step(); step();

        // m0 read with a 3-cycle slave latency, then the mandatory dead cycle
        s0 = 1; a0 = 22'h000004; w0 = 0; lat = 3; din_in = 32'h12345678;
        step();
        for (int i = 1; i <= 4; i++) step();
        check("rd_ack", o_m0_ack, 32'h1);
        check("rd_din", o_m0_din, 32'h12345678);
        check("rd_m1_ack", o_m1_ack, 32'h0);
        step();
        check("dead_cycle", o_bus_stb, 32'h0);
        lat = 0; step();
        s0 = 0; step(); step();

        // m1 write to an unmapped address never acked
        s1 = 1; w1 = 1; a1 = 22'h3FFFC0; d1 = 32'hDEADBEEF; lat = 1000; got = 0; k = 0;
        step();
        for (int i = 1; i <= 12 && !got; i++) begin
            step();
            if (o_tmo) k++;
            if (o_m1_ack) begin
                got = 1;
                check("tmo_cycle", i, TMO);
                check("tmo_din", o_m1_din, 32'h0);
            end
        end
        check("tmo_seen", 32'(got), 32'h1);
        s1 = 0; step();
        if (o_tmo) k++;
        check("tmo_pulses", k, 1);
        check("tmo_addr_cap", 32'(tmo_addr), 32'h003FFFC0);
        check("tmo_mst_cap", tmo_mst, 32'h1);

        // Real ack in the final watchdog cycle wins
        s0 = 1; a0 = 22'h001234; w0 = 0; lat = TMO - 1; din_in = 32'hCAFEF00D; got = 0;
        step();
        for (int i = 1; i <= 12 && !got; i++) begin
            step();
            if (o_m0_ack) begin
                got = 1;
                check("late_cycle", i, TMO);
                check("late_din", o_m0_din, 32'hCAFEF00D);
                check("late_tmo", o_tmo, 32'h0);
            end
        end
        check("late_seen", 32'(got), 32'h1);
        s0 = 0; step();
        check("late_keep_addr", 32'(tmo_addr), 32'h003FFFC0);
        check("late_keep_mst", tmo_mst, 32'h1);

        // Asynchronous reset in the middle of a BUSY cycle
        s0 = 1; a0 = 22'h2AAAAA; lat = 1000;
        step(); step(); step();
        #2;
        do_reset();
        lat = 0;
        step();
        check("post_rst_idle", o_bus_stb, 32'h0);
        step();
        check("post_rst_grant", o_bus_stb, 32'h1);
        check("post_rst_ack", o_m0_ack, 32'h1);
        s0 = 0; step();

        // Owner abandons its request while m1 waits
        s0 = 1; a0 = 22'h000055; lat = 1000;
        step();
        s1 = 1; a1 = 22'h0000AA;
        step();
        s0 = 0;
        step();
        check("drop_stb", o_bus_stb, 32'h0);
        check("drop_m0_ack", o_m0_ack, 32'h0);
        check("drop_m1_ack", o_m1_ack, 32'h0);
        step();
        check("drop_idle", o_bus_stb, 32'h0);
        step();
        check("drop_grant", o_bus_stb, 32'h1);
        check("drop_grant_addr", 32'(o_bus_addr), 32'h000000AA);
        s1 = 0; step(); step();

        // Random traffic
        rand_mode = 1;
        repeat (3000) begin
            step();
            masters_update();
        end
        s0 = 0; s1 = 0; step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
